// File: rtl/sap_pkg.sv
// SAP-1 shared definitions: default widths and the opcode map.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sap_pkg;

  localparam int SAP_DATA_W = 8;
  localparam int SAP_ADDR_W = 4;

  // Opcodes carried in IR[7:4] and decoded by the control sequencer
  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

endpackage

// File: rtl/sap_ram16x8.sv
// SAP program/data memory: synchronous write port, asynchronous read on raddr.
// Latency: write lands at the clock edge; read data follows raddr combinationally.
// Backpressure: none; the caller gates we. Contents are never reset.
module sap_ram16x8 #(
  parameter int DATA_W = sap_pkg::SAP_DATA_W,
  parameter int ADDR_W = sap_pkg::SAP_ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Program-loader write; no reset so a loaded program survives clr
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: W bus, PC/MAR/IR/A/B/OUT registers, add/sub ALU and program RAM.
// Latency: bus and ALU combinational; register loads take effect at the next rising edge.
// Backpressure: none; hlt freezes all registers, prog_mode parks the datapath for RAM loading.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              Cp,
  input  logic              Ep,
  input  logic              Lm,
  input  logic              CE,
  input  logic              Li,
  input  logic              Ei,
  input  logic              La,
  input  logic              Ea,
  input  logic              Su,
  input  logic              Eu,
  input  logic              Lb,
  input  logic              Lo,
  input  logic              hlt,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        instruction,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] bus,
  output logic              bus_conflict
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] outr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] alu;
  logic [4:0]        bus_en;
  logic              multi_drv;
  logic              ram_we;

  // Loader writes are blocked while clr is high so reset wins everywhere
  assign ram_we = prog_mode & prog_we & ~clr;

  sap_ram16x8 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (mar),
    .rdata (ram_rdata)
  );

  // ALU result wraps modulo 2**DATA_W in both directions
  assign alu = Su ? (a - b) : (a + b);

  // More than one bus enable is a sequencer bug; x & (x-1) is nonzero iff >1 bit set
  assign bus_en    = {Ep, CE, Ei, Ea, Eu};
  assign multi_drv = (bus_en & (bus_en - 5'd1)) != 5'd0;

  // W-bus source select, fixed priority Ep > CE > Ei > Ea > Eu, idle bus reads 0
  always_comb begin
    bus = '0;
    if (Ep)      bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
    else if (CE) bus = ram_rdata;
    else if (Ei) bus = {{(DATA_W-4){1'b0}}, ir[3:0]};
    else if (Ea) bus = a;
    else if (Eu) bus = alu;
  end

  // Register file update: clr first, then loader and halt freezes, then the control word
  always_ff @(posedge clock) begin
    if (clr) begin
      pc           <= '0;
      mar          <= '0;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      outr         <= '0;
      out_valid    <= 1'b0;
      bus_conflict <= 1'b0;
    end else if (prog_mode || hlt) begin
      out_valid <= 1'b0;
    end else begin
      if (Cp) pc   <= pc + PC_ONE;
      if (Lm) mar  <= bus[ADDR_W-1:0];
      if (Li) ir   <= bus;
      if (La) a    <= bus;
      if (Lb) b    <= bus;
      if (Lo) outr <= bus;
      out_valid <= Lo;
      if (multi_drv) bus_conflict <= 1'b1;
    end
  end

  assign instruction = ir[DATA_W-1:DATA_W-4];
  assign out_data    = outr;

endmodule

// File: tb/tb_sap_datapath.sv
// Directed bench for sap_datapath: runs a small SAP program plus ALU, PC wrap, conflict, halt and reset cases.
// Latency: one control word per clock; outputs sampled 1 ns after the rising edge.
// Backpressure: none.
module tb_sap_datapath;
  import sap_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  localparam logic [11:0] C_CP = 12'h800;
  localparam logic [11:0] C_EP = 12'h400;
  localparam logic [11:0] C_LM = 12'h200;
  localparam logic [11:0] C_CE = 12'h100;
  localparam logic [11:0] C_LI = 12'h080;
  localparam logic [11:0] C_EI = 12'h040;
  localparam logic [11:0] C_LA = 12'h020;
  localparam logic [11:0] C_EA = 12'h010;
  localparam logic [11:0] C_SU = 12'h008;
  localparam logic [11:0] C_EU = 12'h004;
  localparam logic [11:0] C_LB = 12'h002;
  localparam logic [11:0] C_LO = 12'h001;

  logic          clock = 1'b0;
  logic          clr = 1'b1;
  logic [11:0]   ctl = '0;
  logic          Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo;
  logic          hlt = 1'b0;
  logic          prog_mode = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_data = '0;
  logic [3:0]    instruction;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [DW-1:0] bus;
  logic          bus_conflict;

  int n_cmp = 0;
  int n_bad = 0;

  assign {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo} = ctl;

  always #5 clock = ~clock;

  sap_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock        (clock),
    .clr          (clr),
    .Cp           (Cp),
    .Ep           (Ep),
    .Lm           (Lm),
    .CE           (CE),
    .Li           (Li),
    .Ei           (Ei),
    .La           (La),
    .Ea           (Ea),
    .Su           (Su),
    .Eu           (Eu),
    .Lb           (Lb),
    .Lo           (Lo),
    .hlt          (hlt),
    .prog_mode    (prog_mode),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .instruction  (instruction),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .bus          (bus),
    .bus_conflict (bus_conflict)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clocked control word; controls drop back to idle 1 ns after the edge
  task automatic step(input logic [11:0] c);
    ctl = c;
    @(posedge clock);
    #1;
    ctl = '0;
  endtask

  // Drive bus enables only, read the bus combinationally, then idle through one edge
  task automatic look(input logic [11:0] c, output logic [DW-1:0] v);
    ctl = c;
    #1;
    v = bus;
    ctl = '0;
    @(posedge clock);
    #1;
  endtask

  task automatic fetch();
    step(C_EP | C_LM);
    step(C_CP);
    step(C_CE | C_LI);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step('0);
    clr = 1'b0;
  endtask

  logic [AW-1:0] ld_addr [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB,
                                   4'hC, 4'hD, 4'hE, 4'hF};
  logic [DW-1:0] ld_data [12] = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h10, 8'h14, 8'h18,
                                   8'hFF, 8'h01, 8'h55, 8'h77};

  initial begin
    logic [DW-1:0] v;
    @(posedge clock);
    #1;
    // reset state
    step('0);
    clr = 1'b0;
    chk("rst_bus", bus, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_out", out_data, 0);
    chk("rst_ovld", out_valid, 0);
    chk("rst_conf", bus_conflict, 0);

    // program load
    prog_mode = 1'b1;
    prog_we   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      prog_addr = ld_addr[i];
      prog_data = ld_data[i];
      step('0);
    end
    prog_mode = 1'b0;
    prog_we   = 1'b0;

    // program: LDA 9; ADD A; SUB B; OUT; HLT
    fetch();
    chk("lda_instr", instruction, OP_LDA);
    step(C_EI | C_LM);
    step(C_CE | C_LA);
    look(C_EA, v); chk("lda_a", v, 8'h10);
    fetch();
    chk("add_instr", instruction, OP_ADD);
    step(C_EI | C_LM);
    step(C_CE | C_LB);
    step(C_EU | C_LA);
    look(C_EA, v); chk("add_a", v, 8'h24);
    fetch();
    chk("sub_instr", instruction, OP_SUB);
    step(C_EI | C_LM);
    step(C_CE | C_LB);
    step(C_EU | C_SU | C_LA);
    look(C_EA, v); chk("sub_a", v, 8'h0C);
    fetch();
    chk("out_instr", instruction, OP_OUT);
    chk("pre_ovld", out_valid, 0);
    step(C_EA | C_LO);
    chk("out_ovld", out_valid, 1);
    chk("out_data", out_data, 8'h0C);
    step(C_EP | C_LM);
    chk("out_ovld_end", out_valid, 0);
    step(C_CP);
    step(C_CE | C_LI);
    chk("hlt_instr", instruction, OP_HLT);

    // halt freezes PC, A, OUT
    hlt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(C_CP | C_LA | C_LO | C_EU);
      chk("hlt_ovld", out_valid, 0);
    end
    hlt = 1'b0;
    look(C_EP, v); chk("hlt_pc", v, 8'h05);
    look(C_EA, v); chk("hlt_a", v, 8'h0C);
    chk("hlt_out", out_data, 8'h0C);

    // PC wrap after 16 increments
    do_clr();
    repeat (15) step(C_CP);
    look(C_EP, v); chk("pc_15", v, 8'h0F);
    step(C_CP);
    look(C_EP, v); chk("pc_wrap", v, 8'h00);

    // ALU wrap: A=FF, B=01
    do_clr();
    repeat (12) step(C_CP);
    step(C_EP | C_LM);
    step(C_CE | C_LA);
    step(C_CP);
    step(C_EP | C_LM);
    step(C_CE | C_LB);
    look(C_EA, v); chk("alu_a_ff", v, 8'hFF);
    look(C_EU, v); chk("alu_add_bus", v, 8'h00);
    step(C_EU | C_LA);
    look(C_EA, v); chk("alu_add_a", v, 8'h00);
    look(C_EU | C_SU, v); chk("alu_sub_bus", v, 8'hFF);
    step(C_EU | C_SU | C_LA);
    look(C_EA, v); chk("alu_sub_a", v, 8'hFF);

    // bus conflict: PC=3, A=55
    do_clr();
    repeat (14) step(C_CP);
    step(C_EP | C_LM);
    step(C_CE | C_LA);
    repeat (5) step(C_CP);
    chk("conf_pre", bus_conflict, 0);
    look(C_EP | C_EA, v); chk("conf_bus", v, 8'h03);
    step(C_EP | C_EA);
    chk("conf_set", bus_conflict, 1);
    step('0);
    step('0);
    chk("conf_sticky", bus_conflict, 1);
    do_clr();
    chk("conf_clr", bus_conflict, 0);

    // Cp with Ep in one cycle drives the old PC; CE right after Lm sees the new word
    step(C_EP | C_CP | C_LM);
    step(C_EP | C_CP | C_LM);
    look(C_CE, v); chk("cpep_mar", v, 8'h1A);
    look(C_EP, v); chk("cpep_pc", v, 8'h02);

    // prog_we ignored outside prog_mode; prog_mode ignores controls
    prog_we   = 1'b1;
    prog_addr = 4'h0;
    prog_data = 8'hAA;
    step('0);
    prog_we   = 1'b0;
    prog_mode = 1'b1;
    step(C_CP | C_EP | C_LM);
    prog_mode = 1'b0;
    look(C_EP, v); chk("pmode_pc", v, 8'h02);

    // clr mid-instruction after A=77
    do_clr();
    repeat (15) step(C_CP);
    step(C_EP | C_LM);
    step(C_CE | C_LA);
    look(C_EA, v); chk("mid_a77", v, 8'h77);
    clr = 1'b1;
    step(C_EP | C_LM | C_CP);
    clr = 1'b0;
    look(C_EA, v); chk("mid_a", v, 8'h00);
    look(C_EP, v); chk("mid_pc", v, 8'h00);
    look(C_EI, v); chk("mid_ir", v, 8'h00);
    look(C_EU, v); chk("mid_b", v, 8'h00);
    chk("mid_out", out_data, 0);
    chk("mid_instr", instruction, 0);
    chk("mid_ovld", out_valid, 0);
    look(C_CE, v); chk("mid_ram0", v, 8'h09);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
